// File: rtl/ffd_bank_arb.sv
// Round-robin arbiter granting NREQ requesters write access to one shared WD-bit register.
// Optional grant locking is enabled by defining FFD_ARB_LOCK_EN.
module ffd_bank_arb #(
  parameter int WD   = 8,
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WD-1:0]       wdata,
  input  logic [NREQ-1:0]          lock,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [WD-1:0]            q,
  output logic                     q_valid
);

  localparam int PW = $clog2(NREQ);

`ifdef FFD_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
`endif

  state_t          r_state, w_state_n;
  logic [NREQ-1:0] r_gnt, w_gnt_n;
  logic [PW-1:0]   r_owner, w_owner_n;
  logic [PW-1:0]   r_ptr, w_ptr_n;
  logic [WD-1:0]   r_q;
  logic            r_q_valid;

  logic [NREQ-1:0]   w_avail;
  logic [2*NREQ-1:0] w_rot;
  logic [PW:0]       w_sum;
  logic [PW-1:0]     w_win;
  logic              w_found;
  logic [WD-1:0]     w_wsel;

  // Search starts at ptr: rotate the doubled request vector so bit k is index ptr+k
  always_comb begin
    w_avail = req & ~((r_state != IDLE) ? r_gnt : '0);
    w_rot   = {w_avail, w_avail} >> r_ptr;
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (PW+1)'(k);
        if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
        w_win   = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_wsel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_owner == PW'(k)) w_wsel = wdata[k*WD +: WD];
    end
  end

  always_comb begin
    w_state_n = IDLE;
    w_gnt_n   = '0;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
`ifdef FFD_ARB_LOCK_EN
    if ((r_state != IDLE) && |(r_gnt & lock)) begin
      w_state_n = LOCKED;
      w_gnt_n   = r_gnt;
    end else
`endif
    if (w_found) begin
      w_state_n = GRANT;
      w_gnt_n   = NREQ'(1) << w_win;
      w_owner_n = w_win;
      w_ptr_n   = (w_win == PW'(NREQ-1)) ? '0 : w_win + PW'(1);
    end
  end

  // The write uses the grant held during the cycle that this edge ends
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_gnt     <= w_gnt_n;
      r_owner   <= w_owner_n;
      r_ptr     <= w_ptr_n;
      r_q_valid <= |r_gnt;
      if (|r_gnt) r_q <= w_wsel;
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign q       = r_q;
  assign q_valid = r_q_valid;

endmodule

// File: tb/tb_ffd_bank_arb.sv
// Directed self-checking bench for ffd_bank_arb with WD=8, NREQ=4.
module tb_ffd_bank_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  lock;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;

  int n_pass  = 0;
  int n_total = 0;

  ffd_bank_arb #(.WD(8), .NREQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .lock(lock),
    .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; lock = '0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'hF; lock = '0; wdata = 32'h13121110;
    step(); step();
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt); else n_pass++;
    n_total++; if (q !== 8'h00) $display("FAIL reset_q got %h exp 00", q); else n_pass++;
    n_total++; if (q_valid !== 1'b0) $display("FAIL reset_qv got %b exp 0", q_valid); else n_pass++;
    n_total++; if (owner !== 2'd0) $display("FAIL reset_owner got %0d exp 0", owner); else n_pass++;
    req = '0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; wdata = 32'h00A50000;
    step();
    n_total++; if (gnt !== 4'b0100) $display("FAIL single_gnt got %b exp 0100", gnt); else n_pass++;
    n_total++; if (owner !== 2'd2) $display("FAIL single_owner got %0d exp 2", owner); else n_pass++;
    req = 4'b0000;
    step();
    n_total++; if (gnt !== 4'b0000) $display("FAIL single_gnt_off got %b exp 0000", gnt); else n_pass++;
    n_total++; if (q !== 8'hA5) $display("FAIL single_q got %h exp a5", q); else n_pass++;
    n_total++; if (q_valid !== 1'b1) $display("FAIL single_qv got %b exp 1", q_valid); else n_pass++;
    step();
    n_total++; if (q_valid !== 1'b0) $display("FAIL single_qv_pulse got %b exp 0", q_valid); else n_pass++;
    n_total++; if (q !== 8'hA5) $display("FAIL single_q_hold got %h exp a5", q); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [0:4];
    logic [7:0] exp_q [0:4];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    req = 4'hF; wdata = 32'h13121110;
    step();
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (gnt !== exp_g[k]) $display("FAIL rr_gnt%0d got %b exp %b", k, gnt, exp_g[k]); else n_pass++;
      step();
      n_total++;
      if (q !== exp_q[k] || q_valid !== 1'b1)
        $display("FAIL rr_q%0d got %h/%b exp %h/1", k, q, q_valid, exp_q[k]);
      else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_masking();
    logic [3:0] exp_g0;
    exp_g0 = 4'b0101;
    do_reset();
    req = 4'b0001; wdata = 32'h000000C3;
    for (int k = 0; k < 4; k++) begin
      step();
      n_total++;
      if (gnt[0] !== exp_g0[k] || gnt[3:1] !== 3'b000)
        $display("FAIL mask_gnt%0d got %b exp %b", k, gnt, {3'b000, exp_g0[k]});
      else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    req = 4'b0010; wdata = 32'h0000FF00;
    step();
    n_total++; if (gnt !== 4'b0010) $display("FAIL midrst_gnt got %b exp 0010", gnt); else n_pass++;
    reset = 1'b0;
    step();
    n_total++; if (q !== 8'h00) $display("FAIL midrst_q got %h exp 00", q); else n_pass++;
    n_total++; if (gnt !== 4'b0000) $display("FAIL midrst_gnt_off got %b exp 0000", gnt); else n_pass++;
    n_total++; if (q_valid !== 1'b0) $display("FAIL midrst_qv got %b exp 0", q_valid); else n_pass++;
    reset = 1'b1; req = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g [0:4];
`ifdef FFD_ARB_LOCK_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
    do_reset();
    req = 4'b0011; lock = 4'b0001; wdata = 32'h0000BBAA;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 3) lock = 4'b0000;
      n_total++;
      if (gnt !== exp_g[k]) $display("FAIL b2b_gnt%0d got %b exp %b", k, gnt, exp_g[k]); else n_pass++;
      if (k >= 1) begin
        n_total++;
        if (q_valid !== 1'b1) $display("FAIL b2b_qv%0d got %b exp 1", k, q_valid); else n_pass++;
      end
    end
    req = '0; lock = '0;
  endtask

  initial begin
    reset = 1'b0; req = '0; lock = '0; wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_masking();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ffd_bank_arb.md
FFD_BANK_ARB -- requirements
Module: ffd_bank_arb

Interface
REQ-001 Parameter WD, default 8: width of the shared data register and of each requester data slice.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-low reset; sampled only on rising clk.
REQ-005 Port req  input  NREQ: req[i]=1 means requester i wants to write the shared register.
REQ-006 Port wdata  input  NREQ*WD: slice i, bits [i*WD +: WD], is requester i's write data.
REQ-007 Port lock  input  NREQ: lock[i]=1 asks to keep the grant; used only when FFD_ARB_LOCK_EN is defined.
REQ-008 Port gnt  output  NREQ: registered, one-hot or zero grant vector.
REQ-009 Port owner  output  $clog2(NREQ): registered index of the last granted requester.
REQ-010 Port q  output  WD: shared register contents.
REQ-011 Port q_valid  output  1: registered pulse, 1 in the cycle after q is loaded.

Function
REQ-012 States: IDLE (gnt=0), GRANT (one gnt bit high for one cycle), LOCKED (exists only with FFD_ARB_LOCK_EN).
REQ-013 Arbitration: round-robin; the search starts at index ptr and wraps from NREQ-1 to 0; the first i with req[i]=1 wins.
REQ-014 Latency: req[i] high at edge N with i winning -> gnt[i]=1 and owner=i from edge N until edge N+1.
REQ-015 Write: at the edge ending a gnt[i]=1 cycle, q <= wdata slice i and q_valid <= 1; otherwise q_valid <= 0 and q holds.
REQ-016 Pointer: when gnt[i] is issued, ptr <= (i+1) mod NREQ; ptr holds in all other cycles.
REQ-017 Masking: in a GRANT cycle the currently granted index is excluded from arbitration.
REQ-018 Back-to-back: another requester may be granted in the cycle immediately after a grant; a sole continuous requester is granted every other cycle.
REQ-019 The arbiter samples wdata only in the gnt cycle; dropping req in that cycle does not cancel the write.
REQ-020 If no req is high, the next state is IDLE and gnt=0.
REQ-021 Invariant: gnt is never more than one-hot.

Reset
REQ-022 With reset=0 at a rising edge: gnt=0, owner=0, q=0, q_valid=0, ptr=0, state IDLE.
REQ-023 Reset during GRANT or LOCKED aborts the pending write; q goes to 0 and not to wdata.
REQ-024 In the first cycle after reset is released, arbitration starts from index 0.

Configuration
REQ-025 Macro FFD_ARB_LOCK_EN: defined -> if lock[i]=1 at the edge ending a gnt[i] cycle, the state goes to LOCKED.
REQ-026 In LOCKED, gnt[i] stays high, q reloads wdata slice i every edge, and q_valid stays 1.
REQ-027 LOCKED exits at the first edge with lock[i]=0: that edge performs the final write, then the normal ptr/masking rules apply.
REQ-028 Other requests wait while LOCKED.
REQ-029 Macro FFD_ARB_LOCK_EN undefined: lock is ignored, LOCKED does not exist, and behaviour matches REQ-012..021 exactly.

Verification (WD=8, NREQ=4)
REQ-030 Reset: reset=0 for 2 cycles with req=4'hF -> gnt=0, q=8'h00, q_valid=0, owner=0.
REQ-031 Single request: req=4'b0100 with slice2=8'hA5 -> gnt=4'b0100 one cycle later, then q=8'hA5 with a q_valid pulse one cycle after that.
REQ-032 Round-robin: req=4'hF held with slices 8'h10/8'h11/8'h12/8'h13 -> grant order 0,1,2,3,0 and q follows 10,11,12,13,10.
REQ-033 Masking: req=4'b0001 held -> gnt[0] pattern 1,0,1,0.
REQ-034 Reset mid-grant: reset=0 in the gnt[1] cycle with slice1=8'hFF -> q=8'h00 and the grant is gone next cycle.
REQ-035 Lock (macro defined): req=4'b0011, lock[0]=1 for 3 cycles -> gnt[0] high 4 cycles, q_valid high 4 cycles, then gnt[1].
